// File: rtl/flit_tx_credit_pkg.sv
// rtl/flit_tx_credit_pkg.sv - flit type/state enums and flit field positions for the link transmitter
package flit_tx_credit_pkg;

    localparam int FLIT_W        = 34;
    localparam int FLIT_TYPE_MSB = FLIT_W - 1;
    localparam int FLIT_TYPE_LSB = FLIT_W - 2;

    typedef enum logic [1:0] {
        FT_BODY      = 2'b00,
        FT_HEAD      = 2'b01,
        FT_TAIL      = 2'b10,
        FT_HEAD_TAIL = 2'b11
    } flit_type_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PKT  = 1'b1
    } tx_state_t;

endpackage

// File: rtl/flit_tx_credit_if.sv
// rtl/flit_tx_credit_if.sv - source fifo drain side plus outgoing NoC link with credit return
interface flit_tx_credit_if
    import flit_tx_credit_pkg::*;
#(
    parameter int WIDTH = FLIT_W
);
    logic             fifo_empty_i;
    logic [WIDTH-1:0] fifo_data_i;
    logic             fifo_read_o;
    logic             flit_valid_o;
    logic [WIDTH-1:0] flit_data_o;
    logic             credit_i;

    modport master (
        input  fifo_empty_i,
        input  fifo_data_i,
        input  credit_i,
        output fifo_read_o,
        output flit_valid_o,
        output flit_data_o
    );

    modport slave (
        output fifo_empty_i,
        output fifo_data_i,
        output credit_i,
        input  fifo_read_o,
        input  flit_valid_o,
        input  flit_data_o
    );
endinterface

// File: rtl/flit_tx_credit_cnt.sv
// rtl/flit_tx_credit_cnt.sv - up/down credit counter saturating at CREDITS, flags an excess return
module tx_credit_cnt #(
    parameter int CREDITS = 8,
    parameter int CW      = $clog2(CREDITS + 1)
) (
    input  logic          clk,
    input  logic          arst,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          nonzero_o,
    output logic          overflow_o
);
    localparam logic [CW-1:0] MAX = CW'(CREDITS);

    logic [CW-1:0] count_q, count_d;

    always_comb begin
        count_d    = count_q;
        overflow_o = 1'b0;
        if (dec_i && !inc_i) begin
            count_d = count_q - CW'(1);
        end else if (inc_i && !dec_i) begin
            if (count_q == MAX) begin
                overflow_o = 1'b1;
            end else begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            count_q <= MAX;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign nonzero_o = (count_q != '0);
endmodule

// File: rtl/flit_tx_credit.sv
// rtl/flit_tx_credit.sv - pops flits from the source fifo onto a credit-flow-controlled NoC link
module flit_tx_credit
    import flit_tx_credit_pkg::*;
#(
    parameter int WIDTH   = FLIT_W,
    parameter int CREDITS = 8,
    parameter int PKT_W   = 16
) (
    input  logic                           clk,
    input  logic                           arst,
    flit_tx_credit_if.master               link,
    output logic [$clog2(CREDITS+1)-1:0]   credits_o,
    output logic [PKT_W-1:0]               pkt_cnt_o,
    output logic                           proto_err_o
);
    localparam int CW = $clog2(CREDITS + 1);

    logic             send;
    logic             cnt_nonzero;
    logic             cnt_overflow;
    logic             frame_err;
    logic             pkt_done;
    flit_type_t       ftype;
    tx_state_t        state_q, state_d;
    logic             flit_valid_q;
    logic [WIDTH-1:0] flit_data_q;
    logic [PKT_W-1:0] pkt_cnt_q;
    logic             err_q;

    // A credit arriving this cycle only counts from the next cycle on.
    assign send             = arst && !link.fifo_empty_i && cnt_nonzero;
    assign link.fifo_read_o = send;
    assign ftype            = flit_type_t'(link.fifo_data_i[WIDTH-1:WIDTH-2]);

    tx_credit_cnt #(.CREDITS(CREDITS), .CW(CW)) u_credit_cnt (
        .clk        (clk),
        .arst       (arst),
        .inc_i      (link.credit_i),
        .dec_i      (send),
        .count_o    (credits_o),
        .nonzero_o  (cnt_nonzero),
        .overflow_o (cnt_overflow)
    );

    always_comb begin
        state_d   = state_q;
        frame_err = 1'b0;
        pkt_done  = 1'b0;
        if (send) begin
            case (state_q)
                ST_IDLE: begin
                    case (ftype)
                        FT_HEAD:      state_d  = ST_PKT;
                        FT_HEAD_TAIL: pkt_done = 1'b1;
                        default:      frame_err = 1'b1;
                    endcase
                end
                ST_PKT: begin
                    case (ftype)
                        FT_BODY: state_d = ST_PKT;
                        FT_TAIL: begin
                            state_d  = ST_IDLE;
                            pkt_done = 1'b1;
                        end
                        default: frame_err = 1'b1;
                    endcase
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q      <= ST_IDLE;
            flit_valid_q <= 1'b0;
            flit_data_q  <= '0;
            pkt_cnt_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            flit_valid_q <= send;
            if (send) begin
                flit_data_q <= link.fifo_data_i;
            end
            if (pkt_done) begin
                pkt_cnt_q <= pkt_cnt_q + PKT_W'(1);
            end
            if (frame_err || cnt_overflow) begin
                err_q <= 1'b1;
            end
        end
    end

    assign link.flit_valid_o = flit_valid_q;
    assign link.flit_data_o  = flit_data_q;
    assign pkt_cnt_o         = pkt_cnt_q;
    assign proto_err_o       = err_q;
endmodule

// File: tb/tb_flit_tx_credit.sv
// tb/tb_flit_tx_credit.sv - randomized link transmitter bench against a queue-based reference model
module tb_flit_tx_credit;
    import flit_tx_credit_pkg::*;

    localparam int W = FLIT_W;

    logic       clk;
    logic       arst;
    logic [3:0] credits_o;
    logic [15:0] pkt_cnt_o;
    logic       proto_err_o;

    flit_tx_credit_if #(.WIDTH(W)) link ();

    flit_tx_credit #(.WIDTH(W), .CREDITS(8), .PKT_W(16)) dut (
        .clk         (clk),
        .arst        (arst),
        .link        (link.master),
        .credits_o   (credits_o),
        .pkt_cnt_o   (pkt_cnt_o),
        .proto_err_o (proto_err_o)
    );

    int n_cmp = 0;
    int n_mis = 0;
    int pops_seen = 0;

    logic [W-1:0] q[$];
    int           m_credits;
    bit           m_inpkt;
    int           m_pkt;
    bit           m_err;
    bit           m_valid;
    logic [W-1:0] m_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        link.fifo_empty_i = (q.size() == 0);
        link.fifo_data_i  = (q.size() != 0) ? q[0] : '0;
    endtask

    task automatic push(input logic [1:0] t);
        logic [W-1:0] f;
        f = {t, 32'($urandom)};
        q.push_back(f);
        drive_fifo();
    endtask

    task automatic check_outputs();
        chk("flit_valid", 64'(link.flit_valid_o), 64'(m_valid));
        chk("flit_data",  64'(link.flit_data_o),  64'(m_data));
        chk("credits",    64'(credits_o),         64'(m_credits));
        chk("pkt_cnt",    64'(pkt_cnt_o),         64'(m_pkt % 65536));
        chk("proto_err",  64'(proto_err_o),       64'(m_err));
    endtask

    // Called at posedge+1; returns at the next posedge+1.
    task automatic step(input bit cr);
        bit           snd;
        logic [W-1:0] f;
        link.credit_i = cr;
        #3;
        snd = (q.size() != 0) && (m_credits != 0);
        chk("fifo_read", 64'(link.fifo_read_o), 64'(snd));
        if (link.fifo_read_o === 1'b1) pops_seen++;
        @(posedge clk);
        m_valid = snd;
        if (snd) begin
            f = q.pop_front();
            m_data = f;
            if (!m_inpkt) begin
                if (f[FLIT_TYPE_MSB:FLIT_TYPE_LSB] == 2'b01) m_inpkt = 1'b1;
                else if (f[FLIT_TYPE_MSB:FLIT_TYPE_LSB] == 2'b11) m_pkt++;
                else m_err = 1'b1;
            end else begin
                if (f[FLIT_TYPE_MSB:FLIT_TYPE_LSB] == 2'b10) begin
                    m_inpkt = 1'b0;
                    m_pkt++;
                end else if (f[FLIT_TYPE_MSB:FLIT_TYPE_LSB] != 2'b00) begin
                    m_err = 1'b1;
                end
            end
        end
        if (snd && !cr) m_credits--;
        else if (cr && !snd) begin
            if (m_credits == 8) m_err = 1'b1;
            else m_credits++;
        end
        #1;
        link.credit_i = 1'b0;
        drive_fifo();
        check_outputs();
    endtask

    // Asserts reset mid-cycle so the first check proves it acts without a clock edge.
    task automatic do_reset();
        arst = 1'b0;
        m_credits = 8; m_inpkt = 0; m_pkt = 0; m_err = 0; m_valid = 0; m_data = '0;
        #1;
        check_outputs();
        chk("fifo_read_rst", 64'(link.fifo_read_o), 64'(0));
        repeat (5) @(posedge clk);
        #1;
        check_outputs();
        chk("fifo_read_rst", 64'(link.fifo_read_o), 64'(0));
        arst = 1'b1;
    endtask

    initial begin
        arst = 1'b0;
        link.credit_i = 1'b0;
        drive_fifo();
        @(posedge clk);
        #1;

        // 1: reset with a non-empty fifo
        push(2'b01);
        do_reset();

        // 2: exhaust credits with HEAD, 6 BODY, TAIL, HEAD
        repeat (6) push(2'b00);
        push(2'b10);
        push(2'b01);
        pops_seen = 0;
        repeat (10) step(1'b0);
        chk("exhaust_pops",    64'(pops_seen), 64'(8));
        chk("exhaust_credits", 64'(credits_o), 64'(0));
        chk("exhaust_pkt",     64'(pkt_cnt_o), 64'(1));
        chk("exhaust_held",    64'(link.fifo_empty_i), 64'(0));

        // 3: one credit returns, held HEAD goes out
        step(1'b1);
        chk("ret_credits1", 64'(credits_o), 64'(1));
        step(1'b0);
        chk("ret_valid",  64'(link.flit_valid_o), 64'(1));
        chk("ret_type",   64'(link.flit_data_o[FLIT_TYPE_MSB:FLIT_TYPE_LSB]), 64'(2'b01));
        chk("ret_credits0", 64'(credits_o), 64'(0));

        // 4: simultaneous send and credit at credits=3, then random traffic
        repeat (3) step(1'b1);
        chk("sim_pre", 64'(credits_o), 64'(3));
        push(2'b00);
        step(1'b1);
        chk("sim_hold", 64'(credits_o), 64'(3));
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 2) != 0) push(2'($urandom));
            step(1'($urandom));
        end
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) != 0) push(2'($urandom));
            step(1'($urandom_range(0, 3) == 0));
        end

        // 5: framing errors and single-flit packets
        q.delete();
        drive_fifo();
        do_reset();
        push(2'b00);
        step(1'b0);
        chk("body_idle_err",   64'(proto_err_o), 64'(1));
        chk("body_idle_valid", 64'(link.flit_valid_o), 64'(1));
        do_reset();
        push(2'b01);
        push(2'b01);
        step(1'b0);
        chk("head_ok", 64'(proto_err_o), 64'(0));
        step(1'b0);
        chk("head_head_err", 64'(proto_err_o), 64'(1));
        do_reset();
        repeat (4) push(2'b11);
        repeat (5) step(1'b0);
        chk("ht_pkts", 64'(pkt_cnt_o), 64'(4));
        chk("ht_err",  64'(proto_err_o), 64'(0));

        // 6: credit overflow, then reset in the middle of a packet
        do_reset();
        step(1'b1);
        chk("ovf_err",     64'(proto_err_o), 64'(1));
        chk("ovf_credits", 64'(credits_o), 64'(8));
        push(2'b01);
        push(2'b00);
        push(2'b00);
        step(1'b0);
        chk("mid_valid", 64'(link.flit_valid_o), 64'(1));
        do_reset();
        repeat (4) step(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
